bin_to_sevenseg_seq: RTL and testbench

- Parametrised successor to the team's 4-bit two-digit seven-segment decoder.
- Accepts an unsigned binary value of WIDTH bits over a valid/ready handshake.
- Converts it to DIGITS BCD digits with a sequential double-dabble engine, one shift per clock.
- Drives registered, active-low seven-segment patterns for every digit, plus an overflow flag and a completion pulse. Sits between datapath results and board display pins.

---
 rtl/bin_to_sevenseg_seq.sv | 146 ++++++++++++++
 tb/tb_bin_to_sevenseg_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bin_to_sevenseg_seq.sv
// Sequential binary-to-BCD (double dabble, one shift per clock) driving registered
// active-low seven-segment digits. Define SEVENSEG_LZB_EN for leading-zero blanking.
module bin_to_sevenseg_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin_to_sevenseg_seq: WIDTH must be in 4..32");
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("bin_to_sevenseg_seq: DIGITS must be in 1..10");
  end

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // 10^10-1 needs 34 bits, so the range check is done in 64-bit arithmetic
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]    bin_q;
  logic [BW-1:0]       bcd_q, bcd_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [CW-1:0]       cnt_q;
  logic                ovf_nxt_q;
  logic [7*DIGITS-1:0] seg_nxt;
  logic                accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV;
      CONV:    if (cnt_q == CW'(WIDTH-1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Display image built from the finished BCD; dashes win over digits and blanking
  always_comb begin
`ifdef SEVENSEG_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_nxt = '1;
    for (int i = DIGITS-1; i >= 0; i--) begin
`ifdef SEVENSEG_LZB_EN
      if (bcd_q[4*i +: 4] != 4'd0 || i == 0) lead = 1'b0;
      if (ovf_nxt_q)  seg_nxt[7*i +: 7] = SEG_DASH;
      else if (lead)  seg_nxt[7*i +: 7] = SEG_BLANK;
      else            seg_nxt[7*i +: 7] = enc(bcd_q[4*i +: 4]);
`else
      if (ovf_nxt_q)  seg_nxt[7*i +: 7] = SEG_DASH;
      else            seg_nxt[7*i +: 7] = enc(bcd_q[4*i +: 4]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_nxt_q <= 1'b0;
      seg       <= '1;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bin_q     <= in_data;
          bcd_q     <= '0;
          cnt_q     <= '0;
          ovf_nxt_q <= 64'(in_data) > MAX_VAL;
        end
        CONV: begin
          {bcd_q, bin_q} <= shifted;
          cnt_q          <= cnt_q + CW'(1);
        end
        LOAD: begin
          seg  <= seg_nxt;
          ovf  <= ovf_nxt_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_sevenseg_seq.sv
// Directed bench: an 8-bit/3-digit and an 8-bit/2-digit instance on one clock.
module tb_bin_to_sevenseg_seq;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000,
                         S9 = 7'b0010000, BL = 7'b1111111, DS = 7'b0111111;

  logic        clk = 1'b0, rst = 1'b1;
  logic        va = 1'b0, vb = 1'b0;
  logic [7:0]  da = '0, db = '0;
  logic        ra, rb, done_a, done_b, ovf_a, ovf_b;
  logic [20:0] seg_a;
  logic [13:0] seg_b;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  bin_to_sevenseg_seq #(.WIDTH(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(va), .in_data(da),
    .in_ready(ra), .done(done_a), .ovf(ovf_a), .seg(seg_a));

  bin_to_sevenseg_seq #(.WIDTH(8), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_data(db),
    .in_ready(rb), .done(done_b), .ovf(ovf_b), .seg(seg_b));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({seg_a, done_a, ovf_a, ra} !== {21'h1FFFFF, 3'b001}) begin
        n_fail++; $display("FAIL reset_a cyc%0d: got %h expected %h", i, {seg_a, done_a, ovf_a, ra}, {21'h1FFFFF, 3'b001});
      end
      n_checks++;
      if ({seg_b, done_b, ovf_b, rb} !== {14'h3FFF, 3'b001}) begin
        n_fail++; $display("FAIL reset_b cyc%0d: got %h expected %h", i, {seg_b, done_b, ovf_b, rb}, {14'h3FFF, 3'b001});
      end
    end
  endtask

  task automatic conv_a(input logic [7:0] v, input logic [20:0] exp_seg, input logic exp_ovf, input string name);
    int lat = 0, low = 0;
    n_checks++;
    if (ra !== 1'b1) begin n_fail++; $display("FAIL %s ready_before: got %b expected 1", name, ra); end
    va = 1'b1; da = v; step();
    va = 1'b0; da = ~v;
    while (done_a !== 1'b1 && lat < 20) begin
      if (ra === 1'b0) low++;
      step(); lat++;
    end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL %s latency: got %0d expected 9", name, lat); end
    n_checks++;
    if (low !== 9) begin n_fail++; $display("FAIL %s ready_low: got %0d expected 9", name, low); end
    n_checks++;
    if (seg_a !== exp_seg) begin n_fail++; $display("FAIL %s seg: got %b expected %b", name, seg_a, exp_seg); end
    n_checks++;
    if (ovf_a !== exp_ovf || ra !== 1'b1) begin
      n_fail++; $display("FAIL %s ovf/ready: got %b%b expected %b1", name, ovf_a, ra, exp_ovf);
    end
    step();
    n_checks++;
    if (done_a !== 1'b0 || seg_a !== exp_seg) begin
      n_fail++; $display("FAIL %s pulse_hold: got done=%b seg=%b expected done=0 seg=%b", name, done_a, seg_a, exp_seg);
    end
  endtask

  task automatic conv_b(input logic [7:0] v, input logic [13:0] exp_seg, input logic exp_ovf, input string name);
    int lat = 0;
    vb = 1'b1; db = v; step();
    vb = 1'b0; db = ~v;
    while (done_b !== 1'b1 && lat < 20) begin step(); lat++; end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL %s latency: got %0d expected 9", name, lat); end
    n_checks++;
    if (seg_b !== exp_seg) begin n_fail++; $display("FAIL %s seg: got %b expected %b", name, seg_b, exp_seg); end
    n_checks++;
    if (ovf_b !== exp_ovf) begin n_fail++; $display("FAIL %s ovf: got %b expected %b", name, ovf_b, exp_ovf); end
    step();
  endtask

  task automatic test_overflow();
    conv_b(8'd150, {DS, DS}, 1'b1, "ovf_150");
    conv_b(8'd99,  {S9, S9}, 1'b0, "fit_99");
  endtask

  task automatic test_leading_zero();
`ifdef SEVENSEG_LZB_EN
    conv_a(8'd5, {BL, BL, S5}, 1'b0, "small_5");
`else
    conv_a(8'd5, {S0, S0, S5}, 1'b0, "small_5");
`endif
  endtask

  task automatic test_abort();
    int ndone = 0;
    va = 1'b1; da = 8'd200; step();
    da = 8'd42;
    step(); step(); step();
    rst = 1'b1; va = 1'b0; step();
    rst = 1'b0;
    n_checks++;
    if ({seg_a, done_a, ovf_a, ra} !== {21'h1FFFFF, 3'b001}) begin
      n_fail++; $display("FAIL abort_reset: got %h expected %h", {seg_a, done_a, ovf_a, ra}, {21'h1FFFFF, 3'b001});
    end
    for (int i = 0; i < 15; i++) begin
      step();
      if (done_a === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", ndone); end
    n_checks++;
    if (seg_a !== 21'h1FFFFF) begin n_fail++; $display("FAIL abort_blank: got %b expected all ones", seg_a); end
  endtask

  task automatic test_back_to_back();
    int t = 0, acc0 = -1, acc1 = -1, ndone = 0;
    logic acc_now;
    logic [20:0] exp0;
`ifdef SEVENSEG_LZB_EN
    exp0 = {BL, BL, S0};
`else
    exp0 = {S0, S0, S0};
`endif
    va = 1'b1; da = 8'd255;
    while (ndone < 2 && t < 40) begin
      acc_now = va && ra;
      step(); t++;
      if (acc_now) begin
        if (acc0 < 0) begin acc0 = t; da = 8'd0; end
        else begin acc1 = t; va = 1'b0; end
      end
      if (done_a === 1'b1) begin
        ndone++;
        n_checks++;
        if (ndone == 1 && seg_a !== {S2, S5, S5}) begin
          n_fail++; $display("FAIL b2b_255: got %b expected %b", seg_a, {S2, S5, S5});
        end else if (ndone == 2 && seg_a !== exp0) begin
          n_fail++; $display("FAIL b2b_0: got %b expected %b", seg_a, exp0);
        end
      end
    end
    va = 1'b0;
    n_checks++;
    if (ndone !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    n_checks++;
    if (acc1 - acc0 !== 10) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 10", acc1 - acc0); end
  endtask

  initial begin
    test_reset();
    conv_a(8'd173, {S1, S7, S3}, 1'b0, "conv_173");
    test_overflow();
    test_leading_zero();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
